// File: rtl/ff_mul_serial.sv
// Bit-serial GF(2^WIDTH) multiplier, MSB-first shift-and-add, valid/ready on both sides.
// Optional accumulate mode (in_acc port) is enabled with `define FF_MUL_ACC_EN.
module ff_mul_serial #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'('h1B)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef FF_MUL_ACC_EN
    input  logic             in_acc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_p,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] p_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_step;
    logic [WIDTH-1:0] p_res;
    logic             accept;

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            RUN:     in_ready = 1'b0;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // One Horner step: multiply by x, reduce, then add A for this bit of B.
    always_comb begin
        p_step = {p_r[WIDTH-2:0], 1'b0};
        if (p_r[WIDTH-1])
            p_step = p_step ^ POLY;
        if (b_r[cnt])
            p_step = p_step ^ a_r;
    end

`ifdef FF_MUL_ACC_EN
    logic acc_r;
    // The previous result is added at the end so it is not scaled by x^WIDTH.
    assign p_res = acc_r ? (p_step ^ out_p) : p_step;
`else
    assign p_res = p_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            p_r       <= '0;
            cnt       <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef FF_MUL_ACC_EN
            acc_r     <= 1'b0;
`endif
        end else if (accept) begin
            a_r       <= in_a;
            b_r       <= in_b;
            p_r       <= '0;
            cnt       <= CW'(WIDTH - 1);
            state     <= RUN;
            busy      <= 1'b1;
            out_valid <= 1'b0;
`ifdef FF_MUL_ACC_EN
            acc_r     <= in_acc;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    state <= IDLE;
                end
                RUN: begin
                    p_r <= p_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_p     <= p_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_mul_serial.sv
// Bench for ff_mul_serial: WIDTH=4 and WIDTH=8 instances vs a polynomial reference model.
// Vector table, hand sequences (backpressure, back-to-back, reset), exhaustive and random runs.
module tb_ff_mul_serial;

    logic clk;
    logic rst_n;
    logic ordy;

    logic       iv4, ir4, ov4, busy4;
    logic [3:0] a4, b4, op4;
    logic       iv8, ir8, ov8, busy8;
    logic [7:0] a8, b8, op8;
`ifdef FF_MUL_ACC_EN
    logic       acc8;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit sel;

    logic        ov_s, ir_s, busy_s;
    logic [15:0] op_s;

    assign ov_s   = sel ? ov8   : ov4;
    assign ir_s   = sel ? ir8   : ir4;
    assign busy_s = sel ? busy8 : busy4;
    assign op_s   = sel ? {8'h00, op8} : {12'h000, op4};

    ff_mul_serial #(.WIDTH(4), .POLY(4'h3)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .in_a      (a4),
        .in_b      (b4),
`ifdef FF_MUL_ACC_EN
        .in_acc    (1'b0),
`endif
        .out_valid (ov4),
        .out_ready (ordy),
        .out_p     (op4),
        .busy      (busy4)
    );

    ff_mul_serial #(.WIDTH(8), .POLY(8'h1B)) u8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
`ifdef FF_MUL_ACC_EN
        .in_acc    (acc8),
`endif
        .out_valid (ov8),
        .out_ready (ordy),
        .out_p     (op8),
        .busy      (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Schoolbook carry-less product followed by long division by x^w + poly.
    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                           input int w, input logic [15:0] poly);
        logic [31:0] prod;
        logic [31:0] full;
        prod = '0;
        for (int i = 0; i < w; i++)
            if (b[i]) prod = prod ^ ({16'h0, a} << i);
        full = (32'd1 << w) | {16'h0, poly};
        for (int k = 2 * w - 2; k >= w; k--)
            if (prod[k]) prod = prod ^ (full << (k - w));
        return prod[15:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input bit wide, input logic [15:0] a, input logic [15:0] b);
        int guard;
        sel   = wide;
        guard = 0;
        while (ir_s !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (wide) begin
            a8 = a[7:0]; b8 = b[7:0]; iv8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; iv4 = 1'b1;
        end
        @(negedge clk);
        iv4 = 1'b0;
        iv8 = 1'b0;
    endtask

    // Called at the negedge right after acceptance; counts cycles until out_valid.
    task automatic finish_res(input int lat, input logic [15:0] exp, input string nm, input int hold);
        int cyc;
        bit leak;
        cyc  = 0;
        leak = 0;
        while (ov_s !== 1'b1 && cyc < lat + 20) begin
            if (ir_s !== 1'b0 || busy_s !== 1'b1) leak = 1;
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, cyc, lat);
        check({nm, " in_ready/busy during RUN"}, {31'h0, leak}, 0);
        check({nm, " product"}, {16'h0, op_s}, {16'h0, exp});
        repeat (hold) @(negedge clk);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check({nm, " out_valid drop"}, {31'h0, ov_s}, 0);
    endtask

    typedef struct {
        bit          wide;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        string       nm;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [15:0] ra, rb;

        tbl[0] = '{0, 16'h4,  16'h3,  16'hC,  "w4 4x3"};
        tbl[1] = '{0, 16'h2,  16'h2,  16'h4,  "w4 2x2"};
        tbl[2] = '{0, 16'h5,  16'h8,  16'hE,  "w4 5x8"};
        tbl[3] = '{0, 16'hF,  16'hF,  16'hA,  "w4 15x15"};
        tbl[4] = '{1, 16'h57, 16'h83, 16'hC1, "w8 57x83"};
        tbl[5] = '{1, 16'h57, 16'h13, 16'hFE, "w8 57x13"};
        tbl[6] = '{1, 16'h00, 16'hFF, 16'h00, "w8 00xFF"};

        rst_n = 1'b0;
        ordy  = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0;
`ifdef FF_MUL_ACC_EN
        acc8 = 1'b0;
`endif
        sel = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready8",  {31'h0, ir8},   1);
        check("reset out_valid8", {31'h0, ov8},   0);
        check("reset out_p8",     {24'h0, op8},   0);
        check("reset busy8",      {31'h0, busy8}, 0);
        check("reset in_ready4",  {31'h0, ir4},   1);
        check("reset out_valid4", {31'h0, ov4},   0);
        check("reset out_p4",     {28'h0, op4},   0);
        check("reset busy4",      {31'h0, busy4}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            start(tbl[i].wide, tbl[i].a, tbl[i].b);
            finish_res(tbl[i].wide ? 8 : 4, tbl[i].p, tbl[i].nm, 0);
        end

        // Backpressure, then back-to-back acceptance in the handshake cycle.
        start(1, 16'h57, 16'h83);
        begin
            int cyc;
            cyc = 0;
            while (ov8 !== 1'b1 && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            check("bp latency", cyc, 8);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_p stable",  {24'h0, op8}, 32'hC1);
            check("bp out_valid held", {31'h0, ov8}, 1);
            check("bp in_ready low",   {31'h0, ir8}, 0);
        end
        ordy = 1'b1;
        iv8  = 1'b1;
        a8   = 8'h02;
        b8   = 8'h80;
        #1;
        check("b2b in_ready follows out_ready", {31'h0, ir8}, 1);
        @(negedge clk);
        ordy = 1'b0;
        iv8  = 1'b0;
        check("b2b out_valid after handshake", {31'h0, ov8}, 0);
        finish_res(8, 16'h1B, "b2b 02x80", 0);

        // Reset in the middle of a multiply.
        start(1, 16'hFF, 16'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", {31'h0, ov8},   0);
        check("midrst busy",      {31'h0, busy8}, 0);
        check("midrst in_ready",  {31'h0, ir8},   1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst no output", {31'h0, ov8}, 0);
        start(1, 16'h57, 16'h83);
        finish_res(8, 16'hC1, "after reset 57x83", 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ra = 16'(a);
                rb = 16'(b);
                start(0, ra, rb);
                finish_res(4, gf_mul(ra, rb, 4, 16'h3), "exh4", 0);
            end
        end

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            start(1, ra, rb);
            finish_res(8, gf_mul(ra, rb, 8, 16'h1B), "rand8", $urandom_range(0, 3));
        end

`ifdef FF_MUL_ACC_EN
        acc8 = 1'b0;
        start(1, 16'h57, 16'h83);
        finish_res(8, 16'hC1, "acc0 57x83", 0);
        acc8 = 1'b1;
        start(1, 16'h57, 16'h13);
        acc8 = 1'b0;
        finish_res(8, 16'h3F, "acc1 57x13", 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
